// File: rtl/br_redirect.sv
// Branch-resolution redirect: registered redirect/flush/exception one cycle after resolution, redirect held until rd_ready.
// Optional direct-mapped BTB (BTB_PREDICT_EN) updated one cycle after an accepted resolution, looked up combinationally.
module br_redirect #(
   parameter int PC_SZ       = 32,
   parameter int BTB_ENTRIES = 4
) (
   input  logic             clk_in,
   input  logic             reset_n_in,
   input  logic             res_valid,
   input  logic [PC_SZ-1:0] res_pc,
   input  logic [PC_SZ-1:0] res_br_pc,
   input  logic [PC_SZ-1:0] res_no_br_pc,
   input  logic             res_taken,
   input  logic             res_mis,
   input  logic [PC_SZ-1:0] res_pred_pc,
   input  logic             trap_valid,
   input  logic [PC_SZ-1:0] trap_pc,
   output logic             rd_valid,
   output logic [PC_SZ-1:0] rd_pc,
   input  logic             rd_ready,
   output logic             flush,
   output logic             exc_valid,
   output logic [PC_SZ-1:0] exc_pc,
   output logic [PC_SZ-1:0] exc_tval,
   input  logic [PC_SZ-1:0] lookup_pc,
   output logic             lookup_hit,
   output logic [PC_SZ-1:0] lookup_target,
   output logic [15:0]      mispred_cnt
);

   typedef enum logic {IDLE, REDIRECT} state_t;

   state_t           state, state_nxt;
   logic [PC_SZ-1:0] actual_pc, rd_pc_nxt;
   logic             accept, mispred, exc_fire, flush_nxt;
   logic             unused_bits;

   assign actual_pc   = res_taken ? res_br_pc : res_no_br_pc;
   // Resolutions arriving while a redirect is outstanding are wrong-path; a trap also drops them.
   assign accept      = (state == IDLE) & res_valid & ~trap_valid;
   assign mispred     = accept & ~res_mis & (actual_pc != res_pred_pc);
   assign exc_fire    = accept & res_mis;
   assign rd_valid    = (state == REDIRECT);
   assign unused_bits = ^lookup_pc;

   always_comb begin
      state_nxt = state;
      rd_pc_nxt = rd_pc;
      flush_nxt = 1'b0;
      if (trap_valid) begin
         state_nxt = REDIRECT;
         rd_pc_nxt = trap_pc;
         flush_nxt = 1'b1;
      end else if (mispred) begin
         state_nxt = REDIRECT;
         rd_pc_nxt = actual_pc;
         flush_nxt = 1'b1;
      end else if ((state == REDIRECT) && rd_ready) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state       <= IDLE;
         rd_pc       <= '0;
         flush       <= 1'b0;
         exc_valid   <= 1'b0;
         exc_pc      <= '0;
         exc_tval    <= '0;
         mispred_cnt <= '0;
      end else begin
         state     <= state_nxt;
         rd_pc     <= rd_pc_nxt;
         flush     <= flush_nxt;
         exc_valid <= exc_fire;
         if (exc_fire) begin
            exc_pc   <= res_pc;
            exc_tval <= res_br_pc;
         end
         if (mispred && (mispred_cnt != 16'hFFFF))
            mispred_cnt <= mispred_cnt + 16'd1;
      end
   end

`ifdef BTB_PREDICT_EN
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = PC_SZ - IDX_W - 2;

   logic [BTB_ENTRIES-1:0] btb_vld;
   logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
   logic [PC_SZ-1:0]       btb_tgt [BTB_ENTRIES];

   logic             wr_en, wr_clr;
   logic [IDX_W-1:0] wr_idx, res_idx, lk_idx;
   logic [TAG_W-1:0] wr_tag, res_tag;
   logic [PC_SZ-1:0] wr_tgt;

   assign res_idx = res_pc[IDX_W+1:2];
   assign res_tag = res_pc[PC_SZ-1:IDX_W+2];
   assign lk_idx  = lookup_pc[IDX_W+1:2];

   // Updates are staged one cycle, so a same-cycle lookup always sees the old entry.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         wr_en   <= 1'b0;
         wr_clr  <= 1'b0;
         wr_idx  <= '0;
         wr_tag  <= '0;
         wr_tgt  <= '0;
         btb_vld <= '0;
      end else begin
         wr_en  <= accept & res_taken & ~res_mis;
         wr_clr <= accept & ~res_taken & ~res_mis & btb_vld[res_idx] & (btb_tag[res_idx] == res_tag);
         wr_idx <= res_idx;
         wr_tag <= res_tag;
         wr_tgt <= res_br_pc;
         if (wr_en)
            btb_vld[wr_idx] <= 1'b1;
         else if (wr_clr)
            btb_vld[wr_idx] <= 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         btb_tag[wr_idx] <= wr_tag;
         btb_tgt[wr_idx] <= wr_tgt;
      end
   end

   assign lookup_hit    = btb_vld[lk_idx] & (btb_tag[lk_idx] == lookup_pc[PC_SZ-1:IDX_W+2]);
   assign lookup_target = lookup_hit ? btb_tgt[lk_idx] : '0;
`else
   assign lookup_hit    = 1'b0;
   assign lookup_target = '0;
`endif

endmodule

// File: doc/br_redirect.md
BR_REDIRECT -- requirements
Module: br_redirect

Interface
REQ-001 Parameter: PC_SZ, default 32, program-counter width.
REQ-002 Parameter: BTB_ENTRIES, default 4, branch-target-buffer depth, power of 2.
REQ-003 Ports: clk_in  input  1  single clock, all state on rising edge.
REQ-004 Ports: reset_n_in  input  1  asynchronous active-low reset.
REQ-005 Ports: res_valid  input  1  EXE branch/jump resolution valid, one cycle per instruction.
REQ-006 Ports: res_pc  input  PC_SZ  PC of the resolved instruction.
REQ-007 Ports: res_br_pc, res_no_br_pc  input  PC_SZ  each, taken target and fall-through address from the branch unit.
REQ-008 Ports: res_taken, res_mis  input  1  each, branch-taken flag and target-misaligned flag.
REQ-009 Ports: res_pred_pc  input  PC_SZ  next PC that fetch actually used after res_pc.
REQ-010 Ports: trap_valid  input  1, trap_pc  input  PC_SZ  trap/interrupt redirect request from CSR unit.
REQ-011 Ports: rd_valid  output  1, rd_pc  output  PC_SZ, rd_ready  input  1  redirect handshake to fetch.
REQ-012 Ports: flush  output  1  one-cycle pulse killing IF/ID/EXE wrong-path instructions.
REQ-013 Ports: exc_valid  output  1, exc_pc  output  PC_SZ, exc_tval  output  PC_SZ  misaligned-target exception report.
REQ-014 Ports: lookup_pc  input  PC_SZ, lookup_hit  output  1, lookup_target  output  PC_SZ  fetch prediction port.
REQ-015 Ports: mispred_cnt  output  16  saturating mispredict count.

Function
REQ-016 Actual next PC = res_taken ? res_br_pc : res_no_br_pc; mispredict = res_valid & !res_mis & (actual != res_pred_pc).
REQ-017 FSM states IDLE, REDIRECT; only IDLE accepts res_valid; res_valid in REDIRECT is wrong-path and SHALL be discarded (no counter, BTB, or exception effect).
REQ-018 IDLE + mispredict at edge N: from N+1 rd_valid=1, rd_pc=actual, flush=1 for exactly cycle N+1, state REDIRECT.
REQ-019 REDIRECT: rd_valid and rd_pc held stable until rd_valid&rd_ready sampled high; that edge returns to IDLE, rd_valid=0 next cycle.
REQ-020 rd_ready high in the first REDIRECT cycle completes the transfer in one cycle; rd_ready while IDLE is ignored.
REQ-021 res_valid & res_mis in IDLE: exc_valid=1 one cycle at N+1, exc_pc=res_pc, exc_tval=res_br_pc; no redirect, no flush, no counter increment.
REQ-022 trap_valid, any state: next cycle rd_valid=1, rd_pc=trap_pc, flush=1 pulse, state REDIRECT; overrides pending redirect and simultaneous res_valid (which is dropped).
REQ-023 mispred_cnt increments by 1 per accepted mispredict, saturates at 16'hFFFF.
REQ-024 flush never asserted two consecutive cycles except by back-to-back trap_valid.

Reset
REQ-025 reset_n_in low asynchronously forces IDLE; rd_valid, rd_pc, flush, exc_valid, exc_pc, exc_tval, mispred_cnt all 0; BTB valid bits cleared.
REQ-026 Reset mid-REDIRECT abandons the redirect; no output pulses on the first edge after release.

Configuration
REQ-027 Macro BTB_PREDICT_EN: defined -> BTB_ENTRIES direct-mapped entries indexed by pc[log2(BTB_ENTRIES)+1:2], tag = remaining upper pc bits, plus target.
REQ-028 With BTB_PREDICT_EN: accepted res_valid & res_taken & !res_mis writes {valid,tag,res_br_pc} at edge N+1; accepted not-taken with matching tag clears valid.
REQ-029 With BTB_PREDICT_EN: lookup_hit/lookup_target combinational from lookup_pc; write and lookup to same index same cycle returns old content.
REQ-030 Without BTB_PREDICT_EN: no storage; lookup_hit=0, lookup_target=0; fetch predicts fall-through.

Verification
REQ-031 res_pc=0x100, res_taken=1, res_br_pc=0x200, res_pred_pc=0x104, rd_ready=0 for 3 cycles -> flush one pulse, rd_pc=0x200 held 4 cycles, mispred_cnt=1.
REQ-032 res_taken=0, res_no_br_pc=0x104, res_pred_pc=0x104 -> no rd_valid, no flush, mispred_cnt unchanged.
REQ-033 res_mis=1, res_pc=0x40, res_br_pc=0x42 -> exc_valid one cycle, exc_pc=0x40, exc_tval=0x42, no flush.
REQ-034 mispredict and trap_valid trap_pc=0x80 same cycle -> rd_pc=0x80, single flush, mispred_cnt unchanged.
REQ-035 BTB_PREDICT_EN: taken 0x100->0x200 then lookup_pc=0x100 -> lookup_hit=1, lookup_target=0x200; lookup 0x110 (same index, other tag) -> hit=0.
REQ-036 reset_n_in low during REDIRECT -> rd_valid drops immediately, mispred_cnt=0, lookup_hit=0.
